// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle 32-bit MIPS subset CPU (add/sub/and/or/slt, lw, sw, beq, j) with internal ROM, register file and RAM.
// Define MIPS_CPU_DBG_PORTS_EN to expose combinational debug ports for the current instruction.

module InstrRom #(
  parameter int WORDS = 64
) (
  input  logic                     clk,
  input  logic                     load_en,
  input  logic [$clog2(WORDS)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [31:0]              data
);
  logic [31:0] RAM [WORDS];

  // Load port is tied off at the top; contents are normally preloaded hierarchically.
  always_ff @(posedge clk) begin
    if (load_en) RAM[load_addr] <= load_data;
  end

  assign data = RAM[addr];
endmodule

module RegFile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RAM [32];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) RAM[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : RAM[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : RAM[ra2];
endmodule

module DataMem #(
  parameter int WORDS = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);
  logic [31:0] RAM [WORDS];

  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wd;
  end

  assign rd = RAM[addr];
endmodule

module mips_single_cycle_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Reset
`ifdef MIPS_CPU_DBG_PORTS_EN
  ,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_instr,
  output logic        dbg_wr_en,
  output logic [4:0]  dbg_wr_reg,
  output logic [31:0] dbg_wr_data
`endif
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctl_t;

  logic [31:0] pc, pc_plus4, pc_next, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, reg_wa;
  logic [31:0] imm_sext, rs_val, rt_val, alu_b, alu_result, mem_rdata, reg_wd;
  logic        reg_we, mem_we, use_imm, wb_from_mem, is_beq, is_j;
  logic        reg_we_q, mem_we_q;
  alu_ctl_t    alu_ctl;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
  assign unused_shamt = ^instr[10:6];

  InstrRom #(.WORDS(IMEM_WORDS)) InstrROM_inst (
    .clk(Clk), .load_en(1'b0), .load_addr('0), .load_data(32'd0),
    .addr(pc[IW+1:2]), .data(instr)
  );

  RegFile RegFile_inst (
    .clk(Clk), .we(reg_we_q), .ra1(rs), .ra2(rt), .wa(reg_wa), .wd(reg_wd),
    .rd1(rs_val), .rd2(rt_val)
  );

  DataMem #(.WORDS(DMEM_WORDS)) Mem_inst (
    .clk(Clk), .we(mem_we_q), .addr(alu_result[DW+1:2]), .wd(rt_val), .rd(mem_rdata)
  );

  // Main and ALU control; any unrecognised opcode/funct decodes to a NOP.
  always_comb begin
    alu_ctl     = ALU_ADD;
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    reg_wa      = rd;
    use_imm     = 1'b0;
    wb_from_mem = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    case (opcode)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20:   alu_ctl = ALU_ADD;
          6'h22:   alu_ctl = ALU_SUB;
          6'h24:   alu_ctl = ALU_AND;
          6'h25:   alu_ctl = ALU_OR;
          6'h2A:   alu_ctl = ALU_SLT;
          default: reg_we  = 1'b0;
        endcase
      end
      6'h23: begin
        reg_we      = 1'b1;
        reg_wa      = rt;
        use_imm     = 1'b1;
        wb_from_mem = 1'b1;
      end
      6'h2B: begin
        mem_we  = 1'b1;
        use_imm = 1'b1;
      end
      6'h04:   is_beq = 1'b1;
      6'h02:   is_j   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = use_imm ? imm_sext : rt_val;

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctl)
      ALU_ADD: alu_result = rs_val + alu_b;
      ALU_SUB: alu_result = rs_val - alu_b;
      ALU_AND: alu_result = rs_val & alu_b;
      ALU_OR:  alu_result = rs_val | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign reg_wd = wb_from_mem ? mem_rdata : alu_result;

  // An instruction in flight while reset is asserted must leave no architectural trace.
  assign reg_we_q = reg_we & Reset;
  assign mem_we_q = mem_we & Reset;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (is_j)
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (is_beq && (rs_val == rt_val))
      pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) pc <= 32'd0;
    else        pc <= pc_next;
  end

`ifdef MIPS_CPU_DBG_PORTS_EN
  assign dbg_pc      = pc;
  assign dbg_instr   = instr;
  assign dbg_wr_en   = reg_we_q;
  assign dbg_wr_reg  = reg_wa;
  assign dbg_wr_data = reg_wd;
`endif
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Bench for mips_single_cycle_cpu: preloads ROM/registers/RAM, then checks each retired instruction's effect and next PC.

module tb_mips_single_cycle_cpu;
  logic Clk;
  logic Reset;

  typedef enum {K_REG, K_MEM, K_PC} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    int          idx;
    logic [31:0] value;
  } expect_t;

  expect_t scoreboard[$];
  int checkCount;
  int errorCount;

  mips_single_cycle_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
`ifdef MIPS_CPU_DBG_PORTS_EN
    .dbg_pc(),
    .dbg_instr(),
    .dbg_wr_en(),
    .dbg_wr_reg(),
    .dbg_wr_data(),
`endif
    .Clk(Clk),
    .Reset(Reset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input kind_t kind, input int idx, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.idx   = idx;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  // Advance one clock, then drain every expectation queued for that edge.
  task automatic stepAndCompare();
    expect_t     e;
    logic [31:0] obs;
    @(posedge Clk);
    #1;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      case (e.kind)
        K_REG:   obs = dut.RegFile_inst.RAM[e.idx];
        K_MEM:   obs = dut.Mem_inst.RAM[e.idx];
        default: obs = dut.pc;
      endcase
      checkOutput(e.tag, obs, e.value);
    end
  endtask

  task automatic applyStimulus(input string tag, input kind_t kind, input int idx,
                               input logic [31:0] value, input logic [31:0] nextPc);
    if (kind != K_PC) pushExpect(tag, kind, idx, value);
    pushExpect({tag, "_pc"}, K_PC, 0, nextPc);
    stepAndCompare();
  endtask

  logic [31:0] prog [11];

  initial begin
    checkCount = 0;
    errorCount = 0;
    Reset = 1'b0;
    prog = '{32'h00432020, 32'h8c440004, 32'hac420008, 32'h00831022, 32'h00831025, 32'h00831024,
             32'h0083102a, 32'h10830001, 32'h08000000, 32'h8c620000, 32'h08000000};
    for (int i = 0; i < 11; i++) dut.InstrROM_inst.RAM[i] <= prog[i];
    for (int i = 0; i < 32; i++) begin
      dut.RegFile_inst.RAM[i] <= 32'(4 * i);
      dut.Mem_inst.RAM[i]     <= 32'(4 * i);
    end

    pushExpect("reset_pc", K_PC, 0, 32'h0);
    pushExpect("reset_keeps_r2", K_REG, 2, 32'd8);
    stepAndCompare();
    Reset = 1'b1;

    applyStimulus("p1_add", K_REG, 4, 32'd20, 32'h04);
    applyStimulus("p1_lw",  K_REG, 4, 32'd12, 32'h08);
    applyStimulus("p1_sw",  K_MEM, 4, 32'd8,  32'h0C);
    applyStimulus("p1_sub", K_REG, 2, 32'd0,  32'h10);
    applyStimulus("p1_or",  K_REG, 2, 32'd12, 32'h14);
    applyStimulus("p1_and", K_REG, 2, 32'd12, 32'h18);
    applyStimulus("p1_slt", K_REG, 2, 32'd0,  32'h1C);
    applyStimulus("p1_beq_taken", K_PC, 0, 32'd0, 32'h24);
    applyStimulus("p1_lw_r2", K_REG, 2, 32'd12, 32'h28);
    applyStimulus("p1_j", K_PC, 0, 32'd0, 32'h00);

    applyStimulus("p2_add", K_REG, 4, 32'd24, 32'h04);
    applyStimulus("p2_lw",  K_REG, 4, 32'd8,  32'h08);
    applyStimulus("p2_sw",  K_MEM, 5, 32'd12, 32'h0C);
    applyStimulus("p2_sub", K_REG, 2, 32'hFFFFFFFC, 32'h10);
    applyStimulus("p2_or",  K_REG, 2, 32'd12, 32'h14);
    applyStimulus("p2_and", K_REG, 2, 32'd8,  32'h18);
    applyStimulus("p2_slt", K_REG, 2, 32'd1,  32'h1C);
    applyStimulus("p2_beq_not_taken", K_PC, 0, 32'd0, 32'h20);
    applyStimulus("p2_j", K_PC, 0, 32'd0, 32'h00);

    // Third pass: $2=1, $3=12, $4=8; reset lands on the sw, which would write 1 into Mem[2].
    applyStimulus("p3_add", K_REG, 4, 32'd13, 32'h04);
    applyStimulus("p3_lw",  K_REG, 4, 32'd4,  32'h08);
    Reset = 1'b0;
    applyStimulus("rst_sw_suppressed", K_MEM, 2, 32'd8, 32'h00);
    Reset = 1'b1;
    applyStimulus("rst_restart_add", K_REG, 4, 32'd13, 32'h04);

    // Patch in add $0,$2,$3 and add $5,$0,$3 at the next two words.
    dut.InstrROM_inst.RAM[1] <= 32'h00430020;
    dut.InstrROM_inst.RAM[2] <= 32'h00032820;
    applyStimulus("r0_write_discarded", K_REG, 0, 32'd0, 32'h08);
    applyStimulus("r0_reads_zero", K_REG, 5, 32'd12, 32'h0C);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
